// File: rtl/vram_bus_monitor_pkg.sv
// Shared constants for the VRAM bus monitor: record layout, header bits,
// serialiser state encodings and the record-to-byte mapping.
package vram_bus_monitor_pkg;

    localparam int RECORD_BYTES = 7;
    localparam int REC_W        = 48;
    localparam int BUS_W        = 48;

    // Record bit positions (the synchronised bus uses the same layout,
    // except that the strobes are still active-low there).
    localparam int REC_RD      = 47;
    localparam int REC_WRA     = 46;
    localparam int REC_WRB     = 45;
    localparam int REC_VA14    = 44;
    localparam int REC_VAA_LSB = 30;
    localparam int REC_VAB_LSB = 16;
    localparam int REC_VDA_LSB = 8;
    localparam int REC_VDB_LSB = 0;

    // Header byte layout: {marker, rd, wra, wrb, va14, 000}
    localparam int HDR_MARKER_BIT = 7;
    localparam int HDR_RD_BIT     = 6;
    localparam int HDR_WRA_BIT    = 5;
    localparam int HDR_WRB_BIT    = 4;
    localparam int HDR_VA14_BIT   = 3;

    // Serialiser states
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_LOAD = 2'd1;
    localparam logic [1:0] ST_SEND = 2'd2;
    localparam logic [1:0] ST_GAP  = 2'd3;

    // Idle bus: strobes released (high), everything else zero
    localparam logic [BUS_W-1:0] SYNC_RESET = {3'b111, 45'd0};

    localparam logic [2:0] LAST_BYTE = 3'(RECORD_BYTES - 1);

    function automatic logic [7:0] record_byte(input logic [REC_W-1:0] rec,
                                               input logic [2:0]       idx);
        logic [7:0] b;
        b = 8'h00;
        case (idx)
            3'd0: begin
                b[HDR_MARKER_BIT] = 1'b1;
                b[HDR_RD_BIT]     = rec[REC_RD];
                b[HDR_WRA_BIT]    = rec[REC_WRA];
                b[HDR_WRB_BIT]    = rec[REC_WRB];
                b[HDR_VA14_BIT]   = rec[REC_VA14];
            end
            3'd1:    b = {2'b00, rec[REC_VAA_LSB+8 +: 6]};
            3'd2:    b = rec[REC_VAA_LSB +: 8];
            3'd3:    b = {2'b00, rec[REC_VAB_LSB+8 +: 6]};
            3'd4:    b = rec[REC_VAB_LSB +: 8];
            3'd5:    b = rec[REC_VDA_LSB +: 8];
            3'd6:    b = rec[REC_VDB_LSB +: 8];
            default: b = 8'h00;
        endcase
        return b;
    endfunction

endpackage

// File: rtl/vram_bus_monitor_sync_fifo.sv
// Synchronous FIFO with registered read port: pop_data updates on the
// edge that performs the pop. A push while full succeeds if a pop
// frees the slot in the same cycle.
module vram_bus_monitor_sync_fifo #(
    parameter int WIDTH = 48,
    parameter int DEPTH = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    // Pointer update; reset empties the FIFO
    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Storage write and registered read; a same-slot write when full reads the old entry
    always_ff @(posedge clock) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
        if (do_pop)  pop_data <= mem[rd_ptr[AW-1:0]];
    end

endmodule

// File: rtl/vram_bus_monitor.sv
// Passive VRAM bus observer: synchronises the PPU bus, records one entry
// per completed access, queues it and streams it out as 7 bytes over a
// byte ready/valid port with a mandatory idle cycle after every byte.
module vram_bus_monitor
    import vram_bus_monitor_pkg::*;
#(
    parameter int FIFO_DEPTH  = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        enable_i,
    input  logic        vrd_n_i,
    input  logic        vawr_n_i,
    input  logic        vbwr_n_i,
    input  logic        va14_i,
    input  logic [13:0] vaa_i,
    input  logic [13:0] vab_i,
    input  logic [7:0]  vda_i,
    input  logic [7:0]  vdb_i,
    output logic [7:0]  write_data_o,
    output logic        write_valid_o,
    input  logic        write_ready_i,
    output logic        overflow_o,
    output logic [7:0]  dropped_o
);

    logic [BUS_W-1:0] bus_in;
    logic [BUS_W-1:0] sync_q [SYNC_STAGES];
    logic [BUS_W-1:0] bus_prev_p0;
    logic [2:0]       strobe_now;
    logic [2:0]       rose;
    logic             evt_p1;
    logic [REC_W-1:0] rec_p1;
    logic             push_req;
    logic             push;
    logic             drop;
    logic             pop;
    logic             fifo_full;
    logic             fifo_empty;
    logic [REC_W-1:0] fifo_rdata;
    logic [1:0]       state;
    logic [2:0]       byte_idx;

    assign bus_in = {vrd_n_i, vawr_n_i, vbwr_n_i, va14_i, vaa_i, vab_i, vda_i, vdb_i};

    // Whole bus shares one synchroniser chain so strobes and values stay aligned
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= SYNC_RESET;
            bus_prev_p0 <= SYNC_RESET;
        end else begin
            sync_q[0] <= bus_in;
            for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
            bus_prev_p0 <= sync_q[SYNC_STAGES-1];
        end
    end

    // ---- stage p0 -> p1: rising strobe marks the end of an access ----
    assign strobe_now = sync_q[SYNC_STAGES-1][BUS_W-1 -: 3];
    assign rose       = strobe_now & ~bus_prev_p0[BUS_W-1 -: 3];

    // Register the event with bus values from the cycle the strobe was still low
    always_ff @(posedge clock) begin
        if (reset) evt_p1 <= 1'b0;
        else       evt_p1 <= |rose;
        rec_p1 <= {rose, bus_prev_p0[REC_VA14:0]};
    end

    // ---- stage p1 -> FIFO: push or drop ----
    assign pop      = (state == ST_LOAD);
    assign push_req = evt_p1 && enable_i;
    assign push     = push_req && (!fifo_full || pop);
    assign drop     = push_req && fifo_full && !pop;

    vram_bus_monitor_sync_fifo #(
        .WIDTH (REC_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (push),
        .push_data (rec_p1),
        .pop       (pop),
        .pop_data  (fifo_rdata),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    // Sticky overflow flag and saturating drop counter
    always_ff @(posedge clock) begin
        if (reset) begin
            overflow_o <= 1'b0;
            dropped_o  <= 8'd0;
        end else if (drop) begin
            overflow_o <= 1'b1;
            if (dropped_o != 8'hFF) dropped_o <= dropped_o + 8'd1;
        end
    end

    // ---- FIFO -> serialiser: IDLE/LOAD/SEND/GAP byte sequencer ----
    // A push into an idle, empty FIFO starts LOAD immediately to save a cycle
    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= ST_IDLE;
            byte_idx <= 3'd0;
        end else begin
            case (state)
                ST_IDLE: if (!fifo_empty || push) state <= ST_LOAD;
                ST_LOAD: begin
                    byte_idx <= 3'd0;
                    state    <= ST_SEND;
                end
                ST_SEND: if (write_ready_i) state <= ST_GAP;
                ST_GAP: begin
                    if (byte_idx == LAST_BYTE) begin
                        state <= ST_IDLE;
                    end else begin
                        byte_idx <= byte_idx + 3'd1;
                        state    <= ST_SEND;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // The popped record stays in the FIFO read register for the whole record
    assign write_valid_o = (state == ST_SEND);
    assign write_data_o  = write_valid_o ? record_byte(fifo_rdata, byte_idx) : 8'h00;

endmodule

// File: tb/tb_vram_bus_monitor.sv
// Directed bench for vram_bus_monitor: captured byte stream is compared
// against hand-computed records.
module tb_vram_bus_monitor;

    localparam int FIFO_DEPTH = 16;

    logic        clock = 1'b0;
    logic        reset;
    logic        enable_i;
    logic        vrd_n_i, vawr_n_i, vbwr_n_i;
    logic        va14_i;
    logic [13:0] vaa_i, vab_i;
    logic [7:0]  vda_i, vdb_i;
    logic [7:0]  write_data_o;
    logic        write_valid_o;
    logic        write_ready_i;
    logic        overflow_o;
    logic [7:0]  dropped_o;

    int vectors     = 0;
    int miscompares = 0;
    logic [7:0] cap [$];

    always #5 clock = ~clock;

    vram_bus_monitor #(
        .FIFO_DEPTH  (FIFO_DEPTH),
        .SYNC_STAGES (2)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .enable_i      (enable_i),
        .vrd_n_i       (vrd_n_i),
        .vawr_n_i      (vawr_n_i),
        .vbwr_n_i      (vbwr_n_i),
        .va14_i        (va14_i),
        .vaa_i         (vaa_i),
        .vab_i         (vab_i),
        .vda_i         (vda_i),
        .vdb_i         (vdb_i),
        .write_data_o  (write_data_o),
        .write_valid_o (write_valid_o),
        .write_ready_i (write_ready_i),
        .overflow_o    (overflow_o),
        .dropped_o     (dropped_o)
    );

    // Byte sink: record every accepted byte
    always @(negedge clock) begin
        if (write_valid_o && write_ready_i) cap.push_back(write_data_o);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic set_bus(input logic a14, input logic [13:0] a, input logic [13:0] b,
                           input logic [7:0] da, input logic [7:0] db);
        va14_i = a14; vaa_i = a; vab_i = b; vda_i = da; vdb_i = db;
    endtask

    // One access: selected strobes low 3 clocks, then high 4 clocks
    task automatic access(input logic rd, input logic wra, input logic wrb);
        vrd_n_i = ~rd; vawr_n_i = ~wra; vbwr_n_i = ~wrb;
        ticks(3);
        vrd_n_i = 1'b1; vawr_n_i = 1'b1; vbwr_n_i = 1'b1;
        ticks(4);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        ticks(3);
        reset = 1'b0;
        tick();
    endtask

    task automatic wait_bytes(input string tag, input int n, input int budget);
        int k;
        k = 0;
        while (cap.size() < n && k < budget) begin
            tick();
            k++;
        end
        check(tag, 32'(cap.size()), 32'(n));
    endtask

    task automatic check_record(input string tag, input int base, input logic [7:0] e [7]);
        logic [7:0] got;
        for (int k = 0; k < 7; k++) begin
            got = (base + k < cap.size()) ? cap[base+k] : 8'h00;
            check($sformatf("%s_b%0d", tag, k), 32'(got), 32'(e[k]));
        end
    endtask

    logic [7:0] exp_rd   [7] = '{8'hC8, 8'h12, 8'h34, 8'h05, 8'h67, 8'hAB, 8'hCD};
    logic [7:0] exp_wab  [7] = '{8'hB0, 8'h3F, 8'hFF, 8'h00, 8'h00, 8'h5A, 8'hA5};
    logic [7:0] exp_wa   [7] = '{8'hA0, 8'h3F, 8'hFF, 8'h00, 8'h00, 8'h5A, 8'hA5};
    logic [7:0] exp_wb   [7] = '{8'h90, 8'h3F, 8'hFF, 8'h00, 8'h00, 8'h5A, 8'hA5};
    logic [7:0] exp_bp   [7] = '{8'hC0, 8'h0A, 8'hBC, 8'h20, 8'h01, 8'h11, 8'h22};

    initial begin
        int edges;
        int bad;
        int k;

        reset = 1'b1; enable_i = 1'b1; write_ready_i = 1'b1;
        vrd_n_i = 1'b1; vawr_n_i = 1'b1; vbwr_n_i = 1'b1;
        set_bus(1'b0, 14'h0, 14'h0, 8'h00, 8'h00);

        // Reset values
        ticks(3);
        check("rst_valid", 32'(write_valid_o), 32'd0);
        check("rst_data", 32'(write_data_o), 32'h00);
        check("rst_overflow", 32'(overflow_o), 32'd0);
        check("rst_dropped", 32'(dropped_o), 32'd0);
        reset = 1'b0;
        ticks(10);
        check("no_event_on_release", 32'(cap.size()), 32'd0);

        // Single read: latency, byte values, 1-cycle valid and 1-cycle gaps
        set_bus(1'b1, 14'h1234, 14'h0567, 8'hAB, 8'hCD);
        vrd_n_i = 1'b0;
        ticks(4);
        vrd_n_i = 1'b1;
        edges = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clock);
            edges++;
            @(negedge clock);
            if (write_valid_o) break;
        end
        check("rd_latency_edges", 32'(edges), 32'd5);
        check("rd_b0", 32'(write_data_o), 32'(exp_rd[0]));
        for (int b = 1; b < 7; b++) begin
            @(negedge clock);
            check($sformatf("rd_gap%0d", b), 32'(write_valid_o), 32'd0);
            @(negedge clock);
            check($sformatf("rd_valid%0d", b), 32'(write_valid_o), 32'd1);
            check($sformatf("rd_b%0d", b), 32'(write_data_o), 32'(exp_rd[b]));
        end
        @(negedge clock);
        check("rd_end_idle", 32'(write_valid_o), 32'd0);
        ticks(10);
        check("rd_count", 32'(cap.size()), 32'd7);

        // Both write strobes rising together: one record
        cap.delete();
        set_bus(1'b0, 14'h3FFF, 14'h0000, 8'h5A, 8'hA5);
        access(1'b0, 1'b1, 1'b1);
        wait_bytes("wab_bytes", 7, 60);
        ticks(20);
        check("wab_count", 32'(cap.size()), 32'd7);
        check_record("wab", 0, exp_wab);

        // Write strobes rising one cycle apart: two records
        cap.delete();
        vawr_n_i = 1'b0; vbwr_n_i = 1'b0;
        ticks(3);
        vawr_n_i = 1'b1;
        tick();
        vbwr_n_i = 1'b1;
        wait_bytes("wsplit_bytes", 14, 80);
        ticks(20);
        check("wsplit_count", 32'(cap.size()), 32'd14);
        check_record("wsplit_a", 0, exp_wa);
        check_record("wsplit_b", 7, exp_wb);

        // Backpressure: ready low for 50 cycles after byte 1
        cap.delete();
        set_bus(1'b0, 14'h0ABC, 14'h2001, 8'h11, 8'h22);
        access(1'b1, 1'b0, 1'b0);
        wait_bytes("bp_pre", 2, 40);
        write_ready_i = 1'b0;
        tick();
        check("bp_valid", 32'(write_valid_o), 32'd1);
        check("bp_held", 32'(write_data_o), 32'hBC);
        bad = 0;
        for (int i = 0; i < 49; i++) begin
            tick();
            if (write_valid_o !== 1'b1 || write_data_o !== 8'hBC) bad++;
        end
        check("bp_stable", 32'(bad), 32'd0);
        write_ready_i = 1'b1;
        wait_bytes("bp_bytes", 7, 40);
        ticks(20);
        check("bp_count", 32'(cap.size()), 32'd7);
        check_record("bp", 0, exp_bp);

        // Overflow: FIFO_DEPTH+3 reads with ready low
        cap.delete();
        write_ready_i = 1'b0;
        for (int i = 0; i < FIFO_DEPTH + 3; i++) begin
            set_bus(1'b0, 14'(i), 14'h0, 8'h00, 8'h00);
            access(1'b1, 1'b0, 1'b0);
        end
        ticks(5);
        check("ovf_flag", 32'(overflow_o), 32'd1);
        check("ovf_dropped", 32'(dropped_o), 32'd2);
        write_ready_i = 1'b1;
        wait_bytes("ovf_bytes", (FIFO_DEPTH + 1) * 7, 800);
        ticks(40);
        check("ovf_count", 32'(cap.size()), 32'((FIFO_DEPTH + 1) * 7));
        bad = 0;
        for (int r = 0; r <= FIFO_DEPTH; r++) begin
            if (r * 7 + 2 >= cap.size()) bad++;
            else if (cap[r*7] !== 8'hC0 || cap[r*7+2] !== 8'(r)) bad++;
        end
        check("ovf_order", 32'(bad), 32'd0);

        // Enable low: events ignored and not counted as drops
        do_reset();
        cap.delete();
        check("rst_clears_overflow", 32'(overflow_o), 32'd0);
        enable_i = 1'b0;
        set_bus(1'b1, 14'h1234, 14'h0567, 8'hAB, 8'hCD);
        access(1'b1, 1'b0, 1'b0);
        access(1'b0, 1'b1, 1'b0);
        ticks(30);
        check("dis_no_output", 32'(cap.size()), 32'd0);
        check("dis_dropped", 32'(dropped_o), 32'd0);
        check("dis_overflow", 32'(overflow_o), 32'd0);

        // Queued records still drain after enable drops
        enable_i = 1'b1;
        access(1'b1, 1'b0, 1'b0);
        access(1'b0, 1'b0, 1'b1);
        enable_i = 1'b0;
        wait_bytes("drain_bytes", 14, 80);
        ticks(20);
        check("drain_count", 32'(cap.size()), 32'd14);
        check("drain_hdr0", 32'(cap[0]), 32'hC8);
        check("drain_hdr1", 32'(cap[7]), 32'h98);

        // Reset while byte 3 is on the port
        cap.delete();
        enable_i = 1'b1;
        access(1'b1, 1'b0, 1'b0);
        k = 0;
        while (!(write_valid_o && cap.size() == 3) && k < 100) begin
            tick();
            k++;
        end
        check("mid_reached_b3", 32'(write_valid_o && cap.size() == 3), 32'd1);
        check("mid_b3_data", 32'(write_data_o), 32'h05);
        reset = 1'b1;
        tick();
        check("mid_valid_drop", 32'(write_valid_o), 32'd0);
        check("mid_data_zero", 32'(write_data_o), 32'h00);
        check("mid_overflow", 32'(overflow_o), 32'd0);
        check("mid_dropped", 32'(dropped_o), 32'd0);
        reset = 1'b0;
        ticks(40);
        check("mid_abandoned", 32'(cap.size()), 32'd4);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
